// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: main-decoder opcodes, HI/LO unit op encoding and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   // Main decoder primary opcodes (instr[31:26])
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_J     = 6'b000010;

   // Multiply/divide operation select driven by EX
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_signed(input muldiv_op_t o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_div(input muldiv_op_t o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers (mult/multu/div/divu, mthi/mtlo).
// Latency: busy for 33 cycles after start is accepted; done pulses the cycle after HI/LO update.
// Backpressure: none accepted mid-operation; start/hlwrite are ignored while busy, pipeline stalls on busy.
// Ports: clk, reset (sync, active high); start/op/a/b launch an op; hlwrite/hlsel/wdata write HI or LO
//        directly when idle; busy, done, hi, lo are all driven straight from flops.
module muldiv_unit
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hlwrite,
   input  logic        hlsel,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_q, op_d;
   logic [4:0]    count_q, count_d;
   logic [63:0]   acc_q, acc_d;     // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0]   opb_q, opb_d;     // |multiplicand| or |divisor|
   logic          qneg_q, qneg_d;   // negate product / quotient in FIX
   logic          rneg_q, rneg_d;   // negate remainder in FIX
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;

   muldiv_op_t  op_in;
   logic        in_signed;
   logic [31:0] a_mag, b_mag;
   logic [32:0] add_sum, sub_diff;
   logic [63:0] mul_next, div_next;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   assign op_in     = muldiv_op_t'(op);
   assign in_signed = op_is_signed(op_in);
   // Magnitudes only for signed ops; 32'h80000000 maps to itself, which is correct read as unsigned.
   assign a_mag     = (in_signed && a[31]) ? -a : a;
   assign b_mag     = (in_signed && b[31]) ? -b : b;

   // Shift-add step: conditionally add into the upper half, then shift the 65-bit result right.
   assign add_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:32], acc_q[31:1]};

   // Restoring divide step: trial-subtract from the left-shifted remainder; the 33rd bit of the
   // remainder-in-progress comes from acc_q[63:31], and bit 32 of the difference is the borrow.
   assign sub_diff = acc_q[63:31] - {1'b0, opb_q};
   assign div_next = sub_diff[32] ? {acc_q[62:0], 1'b0} : {sub_diff[31:0], acc_q[30:0], 1'b1};

   assign prod_fix = qneg_q ? -acc_q : acc_q;
   assign quot_fix = qneg_q ? -acc_q[31:0] : acc_q[31:0];
   assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               // start wins over a simultaneous hlwrite
               op_d    = op_in;
               count_d = 5'd0;
               acc_d   = {32'd0, a_mag};
               opb_d   = b_mag;
               qneg_d  = in_signed && (a[31] ^ b[31]);
               rneg_d  = in_signed && a[31];
               state_d = MD_RUN;
            end else if (hlwrite) begin
               if (hlsel) hi_d = wdata;
               else       lo_d = wdata;
            end
         end
         MD_RUN: begin
            acc_d   = op_is_div(op_q) ? div_next : mul_next;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) state_d = MD_FIX;
         end
         MD_FIX: begin
            if (op_is_div(op_q)) begin
               // Zero divisor: the quotient is all ones and the remainder is |a|,
               // which rem_fix restores to a.
               lo_d = (opb_q == 32'd0) ? 32'hFFFF_FFFF : quot_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         op_q    <= OP_MULT;
         count_q <= 5'd0;
         acc_q   <= 64'd0;
         opb_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != MD_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, timing, HI/LO writes, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hlwrite;
   logic        hlsel;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .hlwrite (hlwrite),
      .hlsel   (hlsel),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch one op, then watch a fixed 60-cycle window counting busy cycles and done pulses.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bcyc, output int dcnt);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      bcyc = 0;
      dcnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (busy) bcyc++;
         if (done) dcnt++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       tag;
      logic [1:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int bc;
      int dc;

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hlwrite = 1'b0; hlsel = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_hi", hi, 32'd0);
      check_val("rst_lo", lo, 32'd0);
      reset = 1'b0;

      // Timing on the first op after reset
      do_op(2'b00, 32'hFFFF_FFFD, 32'd7, bc, dc);
      check_val("mult_busy_cycles", bc, 33);
      check_val("mult_done_pulses", dc, 1);
      check_val("mult_hi", hi, 32'hFFFF_FFFF);
      check_val("mult_lo", lo, 32'hFFFF_FFEB);

      vecs.push_back('{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{"divu_by0",    2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF});
      vecs.push_back('{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
      vecs.push_back('{"div_m7_by0",  2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
      vecs.push_back('{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
      vecs.push_back('{"divu_big",    2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF});
      vecs.push_back('{"mult_min2",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
      vecs.push_back('{"multu_min2",  2'b01, 32'h8000_0000, 32'd4,         32'd2,         32'd0});

      foreach (vecs[i]) begin
         do_op(vecs[i].o, vecs[i].x, vecs[i].y, bc, dc);
         check_val({vecs[i].tag, "_hi"}, hi, vecs[i].exp_hi);
         check_val({vecs[i].tag, "_lo"}, lo, vecs[i].exp_lo);
         check_val({vecs[i].tag, "_busy"}, bc, 33);
      end

      // Direct HI then LO write in IDLE
      @(negedge clk);
      hlwrite = 1'b1; hlsel = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk);
      hlwrite = 1'b0;
      check_val("mthi_hi", hi, 32'h0000_1234);
      check_val("mthi_lo_kept", lo, 32'd0);
      hlwrite = 1'b1; hlsel = 1'b0; wdata = 32'h0000_5678;
      @(negedge clk);
      hlwrite = 1'b0;
      check_val("mtlo_lo", lo, 32'h0000_5678);
      check_val("mtlo_hi_kept", hi, 32'h0000_1234);

      // hlwrite while busy is ignored; HI/LO change only at FIX
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      hlwrite = 1'b1; hlsel = 1'b1; wdata = 32'h0000_DEAD;
      repeat (5) @(negedge clk);
      check_val("busy_wr_busy", {31'd0, busy}, 32'd1);
      check_val("busy_wr_hi", hi, 32'h0000_1234);
      check_val("busy_wr_lo", lo, 32'h0000_5678);
      hlwrite = 1'b0;
      repeat (40) @(negedge clk);
      check_val("busy_wr_res_hi", hi, 32'd0);
      check_val("busy_wr_res_lo", lo, 32'd6);

      // start and hlwrite together: start wins
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd4; b = 32'd5;
      hlwrite = 1'b1; hlsel = 1'b0; wdata = 32'h0000_AAAA;
      @(negedge clk);
      start = 1'b0; hlwrite = 1'b0;
      check_val("both_busy", {31'd0, busy}, 32'd1);
      check_val("both_lo_nowrite", lo, 32'd6);
      repeat (40) @(negedge clk);
      check_val("both_res_hi", hi, 32'd0);
      check_val("both_res_lo", lo, 32'd20);

      // Reset mid-RUN aborts the op and clears HI/LO
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_done", {31'd0, done}, 32'd0);
      check_val("abort_hi", hi, 32'd0);
      check_val("abort_lo", lo, 32'd0);
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      check_val("abort_no_done", dc, 0);

      do_op(2'b00, 32'd6, 32'hFFFF_FFF9, bc, dc);
      check_val("post_abort_hi", hi, 32'hFFFF_FFFF);
      check_val("post_abort_lo", lo, 32'hFFFF_FFD6);
      check_val("post_abort_done", dc, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk (rising edge only) and reset.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  multordiv request from EX; starts an operation.
REQ-005 op  input  2  operation: MULT=00, MULTU=01, DIV=10, DIVU=11.
REQ-006 a  input  32  multiplicand or dividend (rs).
REQ-007 b  input  32  multiplier or divisor (rt).
REQ-008 hlwrite  input  1  direct HI/LO write (mthi/mtlo).
REQ-009 hlsel  input  1  write target: 0 = LO, 1 = HI.
REQ-010 wdata  input  32  data for hlwrite.
REQ-011 busy  output  1  operation in progress; pipeline stalls on it.
REQ-012 done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-013 hi  output  32  HI register, read by mfhi.
REQ-014 lo  output  32  LO register, read by mflo.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 In IDLE, start=1 at edge k SHALL latch op, |a|, |b| and the result signs (signed ops only), clear the 5-bit count, and enter RUN.
REQ-017 RUN SHALL do one iteration per edge: shift-add for multiply, restoring shift-subtract for divide; count increments every edge; after the 32nd iteration (edge k+32) the FSM enters FIX.
REQ-018 FIX SHALL apply sign correction at edge k+33, write HI/LO, and return to IDLE; done=1 for exactly the cycle after edge k+33; busy is high for exactly 33 cycles.
REQ-019 Multiply SHALL give {HI,LO} = full 64-bit product: two's complement for MULT, unsigned for MULTU.
REQ-020 Divide SHALL give LO = quotient truncated toward zero and HI = remainder with the dividend's sign.
REQ-021 Divide by zero SHALL give LO=32'hFFFFFFFF and HI=a, for both DIV and DIVU, with normal 33-cycle timing.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-023 start and hlwrite SHALL be ignored while busy; HI/LO are not modified until FIX.
REQ-024 In IDLE with hlwrite=1 and start=0, the selected register SHALL load wdata at the next edge; the other register is unchanged.
REQ-025 In IDLE with start=1 and hlwrite=1 together, start SHALL take priority and hlwrite is dropped.
REQ-026 hi and lo SHALL be driven directly from registers (no combinational path from inputs); done SHALL be registered.
REQ-027 Arithmetic SHALL use a 64-bit product/remainder accumulator and a 33-bit subtractor; operands are taken as magnitudes only for MULT and DIV.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0 and count=0, including in RUN or FIX (the operation is aborted with no HI/LO write).
REQ-029 The first start SHALL be accepted at the first edge after reset deasserts.

Structure
REQ-030 The muldiv_op_t encoding (REQ-005) and the state enum SHALL be defined in the shared mips_pkg package, alongside the main decoder's opcode constants.
REQ-031 The block SHALL be a single module with no sub-modules; the iteration datapath stays inline.

Verification
REQ-032 MULT a=-3 (32'hFFFFFFFD), b=7 -> busy high for 33 cycles; done pulses once; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-033 MULTU a=b=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-034 DIV a=-7, b=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU a=100, b=0 -> LO=32'hFFFFFFFF, HI=100.
REQ-035 hlwrite hlsel=1 wdata=32'h1234 in IDLE -> HI=32'h1234 next cycle; the same write during busy -> ignored, HI keeps its old value until FIX.
REQ-036 reset asserted at RUN count=10 -> next cycle: IDLE, busy=0, HI=LO=0, no done pulse; a new MULT then completes correctly.
REQ-037 start and hlwrite asserted together in IDLE -> operation starts; the HI/LO write is dropped.
